// File: rtl/aes256_key_expansion_if.sv
// -----------------------------------------------------------------------------
// aes256_key_expansion_if
// Bus bundle between the AES-256 key schedule and its user.
//   key_load_i     : load request, sampled on the rising clock edge
//   key_i          : 256-bit cipher key, key_i[255:224] = w0 ... key_i[31:0] = w7
//   round_num_i    : round-key index 0..14
//   round_key_o    : {w[4r], w[4r+1], w[4r+2], w[4r+3]} for r = round_num_i
//   busy_o         : expansion in progress
//   key_exp_done_o : all 60 schedule words are valid
//   key_clear_i    : zeroize request, present only with AES256_KEYEXP_ZEROIZE_EN
// Modports: slave = key schedule, master = key owner / round logic.
// -----------------------------------------------------------------------------
interface aes256_key_expansion_if;
  logic         key_load_i;
  logic [255:0] key_i;
  logic [3:0]   round_num_i;
  logic [127:0] round_key_o;
  logic         busy_o;
  logic         key_exp_done_o;
`ifdef AES256_KEYEXP_ZEROIZE_EN
  logic         key_clear_i;
`endif

  modport slave (
    input  key_load_i,
    input  key_i,
    input  round_num_i,
`ifdef AES256_KEYEXP_ZEROIZE_EN
    input  key_clear_i,
`endif
    output round_key_o,
    output busy_o,
    output key_exp_done_o
  );

  modport master (
    output key_load_i,
    output key_i,
    output round_num_i,
`ifdef AES256_KEYEXP_ZEROIZE_EN
    output key_clear_i,
`endif
    input  round_key_o,
    input  busy_o,
    input  key_exp_done_o
  );
endinterface

// File: rtl/aes256_key_expansion.sv
// -----------------------------------------------------------------------------
// aes256_key_expansion
// Iterative AES-256 key schedule. A load latches w0..w7 from the cipher key,
// then one schedule word w8..w59 is produced per clock using a single shared
// SubWord (four S-box lookups). All 60 words are held in storage and read back
// combinationally as 128-bit round keys.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : aes256_key_expansion_if.slave (load, key, round select, round key,
//            busy, done, optional clear)
// Build option:
//   AES256_KEYEXP_ZEROIZE_EN : adds key_clear_i; clear and reset zero the
//   storage. Without it, storage has no reset or clear path.
// -----------------------------------------------------------------------------
module aes256_key_expansion #(
  parameter int NR = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  aes256_key_expansion_if.slave    bus
);

  localparam int         NW       = 4 * (NR + 1);
  localparam logic [5:0] LAST_IDX = 6'(NW - 1);

  // Standard AES S-box, element 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_lookup(x[31:24]), sbox_lookup(x[23:16]),
            sbox_lookup(x[15:8]),  sbox_lookup(x[7:0])};
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] w_q [0:NW-1];
  logic [31:0] w_d [0:NW-1];

  logic        load_words_s;
  logic        write_word_s;
  logic        clear_words_s;
  logic [31:0] prev_word_s;
  logic [31:0] back_word_s;
  logic [7:0]  rcon_s;
  logic [31:0] temp_s;
  logic [31:0] new_word_s;
  logic [5:0]  base_s;
  logic [127:0] round_key_s;

  // Next schedule word w[i] = w[i-8] ^ t, with t chosen by i mod 8.
  always_comb begin
    prev_word_s = w_q[cnt_q - 6'd1];
    back_word_s = w_q[cnt_q - 6'd8];
    // i/8 runs 1..7 here, so Rcon is 01 shifted left by (i/8 - 1).
    rcon_s      = 8'h01 << (cnt_q[5:3] - 3'd1);
    case (cnt_q[2:0])
      3'd0:    temp_s = sub_word({prev_word_s[23:0], prev_word_s[31:24]}) ^ {rcon_s, 24'h000000};
      3'd4:    temp_s = sub_word(prev_word_s);
      default: temp_s = prev_word_s;
    endcase
    new_word_s = back_word_s ^ temp_s;
  end

  // FSM next-state, word counter and status flags.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    done_d        = done_q;
    load_words_s  = 1'b0;
    write_word_s  = 1'b0;
    clear_words_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.key_load_i) begin
          state_d      = ST_EXPAND;
          cnt_d        = 6'd8;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          load_words_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_EXPAND: begin
        // Loads are ignored here; the running expansion always completes.
        write_word_s = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 6'd0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
`ifdef AES256_KEYEXP_ZEROIZE_EN
    // Clear wins over any load or expansion step on the same edge.
    if (bus.key_clear_i) begin
      state_d       = ST_IDLE;
      cnt_d         = 6'd0;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      load_words_s  = 1'b0;
      write_word_s  = 1'b0;
      clear_words_s = 1'b1;
    end else begin
      clear_words_s = 1'b0;
    end
`endif
  end

  // FSM, counter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Storage update: zeroize, key load (w0..w7), or one expanded word.
  always_comb begin
    for (int j = 0; j < NW; j++) begin
      w_d[j] = w_q[j];
    end
    if (clear_words_s) begin
      for (int j = 0; j < NW; j++) begin
        w_d[j] = 32'h00000000;
      end
    end else if (load_words_s) begin
      for (int k = 0; k < 8; k++) begin
        w_d[k] = bus.key_i[255 - 32*k -: 32];
      end
    end else if (write_word_s) begin
      w_d[cnt_q] = new_word_s;
    end else begin
      w_d[0] = w_q[0];
    end
  end

`ifdef AES256_KEYEXP_ZEROIZE_EN
  // Key storage, zeroed by reset in the zeroize build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NW; j++) begin
        w_q[j] <= 32'h00000000;
      end
    end else begin
      w_q <= w_d;
    end
  end
`else
  // Key storage without reset.
  always_ff @(posedge clk) begin
    w_q <= w_d;
  end
`endif

  // Round-key read port, zero for out-of-range indices.
  always_comb begin
    base_s = {bus.round_num_i, 2'b00};
    if (bus.round_num_i > 4'(NR)) begin
      round_key_s = 128'h0;
    end else begin
      round_key_s = {w_q[base_s], w_q[base_s + 6'd1],
                     w_q[base_s + 6'd2], w_q[base_s + 6'd3]};
    end
  end

  assign bus.round_key_o    = round_key_s;
  assign bus.busy_o         = busy_q;
  assign bus.key_exp_done_o = done_q;

endmodule

// File: tb/tb_aes256_key_expansion.sv
// -----------------------------------------------------------------------------
// tb_aes256_key_expansion
// Directed bench for the AES-256 key schedule using the FIPS-197 A.3 and C.3
// keys. A small independent software-style key-expansion model supplies the
// full-schedule expectations for the round-key sweep.
// -----------------------------------------------------------------------------
module tb_aes256_key_expansion;

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [31:0] exp_w [0:59];

  aes256_key_expansion_if bus();

  aes256_key_expansion dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_sub(input logic [31:0] x);
    logic [7:0] b0, b1, b2, b3;
    b0 = x[31:24]; b1 = x[23:16]; b2 = x[15:8]; b3 = x[7:0];
    return {SBOX[b0], SBOX[b1], SBOX[b2], SBOX[b3]};
  endfunction

  // Reference key expansion, straight from the FIPS-197 pseudo-code.
  function automatic void model_expand(input logic [255:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) exp_w[i] = k[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = exp_w[i-1];
      if (i % 8 == 0) begin
        rc = 8'h01;
        rc = rc << (i/8 - 1);
        t  = m_sub({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
      end else if (i % 8 == 4) begin
        t = m_sub(t);
      end
      exp_w[i] = exp_w[i-8] ^ t;
    end
  endfunction

  task automatic load_key(input logic [255:0] k);
    @(negedge clk);
    bus.key_load_i = 1'b1;
    bus.key_i      = k;
    @(negedge clk);
    bus.key_load_i = 1'b0;
  endtask

  // Count negedges with busy high; bounded so a stuck DUT cannot hang the run.
  task automatic wait_expansion(output int cycles);
    cycles = 0;
    while (bus.busy_o === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    total++;
    if (bus.key_exp_done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.key_exp_done_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fips_a3();
    int cycles;
    logic [127:0] exp_tab [0:4];
    int rr [0:4];
    exp_tab = '{128'h603deb1015ca71be2b73aef0857d7781, 128'h1f352c073b6108d72d9810a30914dff4,
                128'h9ba354118e6925afa51a8b5f2067fcde, 128'ha8b09c1a93d194cdbe49846eb75d5b9a,
                128'hfe4890d1e6188d0b046df344706c631e};
    rr = '{0, 1, 2, 3, 14};
    load_key(KEY_A3);
    total++;
    if (bus.key_exp_done_o !== 1'b0) begin bad++; $display("FAIL a3_done_during got=%b exp=0", bus.key_exp_done_o); end
    wait_expansion(cycles);
    total++;
    if (cycles !== 52) begin bad++; $display("FAIL a3_busy_cycles got=%0d exp=52", cycles); end
    total++;
    if (bus.key_exp_done_o !== 1'b1) begin bad++; $display("FAIL a3_done got=%b exp=1", bus.key_exp_done_o); end
    for (int i = 0; i < 5; i++) begin
      bus.round_num_i = 4'(rr[i]);
      #1;
      total++;
      if (bus.round_key_o !== exp_tab[i]) begin
        bad++; $display("FAIL a3_r%0d got=%h exp=%h", rr[i], bus.round_key_o, exp_tab[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [127:0] expv;
    model_expand(KEY_A3);
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      bus.round_num_i = 4'(r);
      #1;
      expv = (r > 14) ? 128'h0 : {exp_w[4*r], exp_w[4*r+1], exp_w[4*r+2], exp_w[4*r+3]};
      total++;
      if (bus.round_key_o !== expv) begin
        bad++; $display("FAIL sweep_r%0d got=%h exp=%h", r, bus.round_key_o, expv);
      end
    end
  endtask

  task automatic test_load_held();
    int cycles;
    @(negedge clk);
    bus.key_load_i = 1'b1;
    bus.key_i      = KEY_A3;
    @(negedge clk);
    cycles = 0;
    while (bus.busy_o === 1'b1 && cycles < 200) begin
      cycles++;
      if (cycles == 10) bus.key_i = KEY_C3;
      @(negedge clk);
    end
    bus.key_load_i = 1'b0;
    total++;
    if (cycles !== 52) begin bad++; $display("FAIL held_busy_cycles got=%0d exp=52", cycles); end
    total++;
    if (bus.key_exp_done_o !== 1'b1) begin bad++; $display("FAIL held_done got=%b exp=1", bus.key_exp_done_o); end
    bus.round_num_i = 4'd14;
    #1;
    total++;
    if (bus.round_key_o !== 128'hfe4890d1e6188d0b046df344706c631e) begin
      bad++; $display("FAIL held_r14 got=%h exp=fe4890d1e6188d0b046df344706c631e", bus.round_key_o);
    end
    bus.round_num_i = 4'd2;
    #1;
    total++;
    if (bus.round_key_o !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin
      bad++; $display("FAIL held_r2 got=%h exp=9ba354118e6925afa51a8b5f2067fcde", bus.round_key_o);
    end
  endtask

  task automatic test_reset_mid();
    int cycles;
    load_key(KEY_A3);
    repeat (19) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy_o); end
    total++;
    if (bus.key_exp_done_o !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", bus.key_exp_done_o); end
    @(negedge clk);
    rst_n = 1'b1;
    load_key(KEY_A3);
    wait_expansion(cycles);
    total++;
    if (cycles !== 52) begin bad++; $display("FAIL midrst_busy_cycles got=%0d exp=52", cycles); end
    bus.round_num_i = 4'd14;
    #1;
    total++;
    if (bus.round_key_o !== 128'hfe4890d1e6188d0b046df344706c631e) begin
      bad++; $display("FAIL midrst_r14 got=%h exp=fe4890d1e6188d0b046df344706c631e", bus.round_key_o);
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    logic [127:0] exp14;
    model_expand(KEY_C3);
    exp14 = {exp_w[56], exp_w[57], exp_w[58], exp_w[59]};
    @(negedge clk);
    bus.key_load_i = 1'b1;
    bus.key_i      = KEY_C3;
    @(posedge clk);
    #1;
    total++;
    if (bus.key_exp_done_o !== 1'b0) begin bad++; $display("FAIL reload_done_drop got=%b exp=0", bus.key_exp_done_o); end
    total++;
    if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL reload_busy got=%b exp=1", bus.busy_o); end
    @(negedge clk);
    bus.key_load_i = 1'b0;
    wait_expansion(cycles);
    total++;
    if (cycles !== 52) begin bad++; $display("FAIL reload_busy_cycles got=%0d exp=52", cycles); end
    total++;
    if (bus.key_exp_done_o !== 1'b1) begin bad++; $display("FAIL reload_done got=%b exp=1", bus.key_exp_done_o); end
    bus.round_num_i = 4'd0;
    #1;
    total++;
    if (bus.round_key_o !== 128'h000102030405060708090a0b0c0d0e0f) begin
      bad++; $display("FAIL reload_r0 got=%h exp=000102030405060708090a0b0c0d0e0f", bus.round_key_o);
    end
    bus.round_num_i = 4'd1;
    #1;
    total++;
    if (bus.round_key_o !== 128'h101112131415161718191a1b1c1d1e1f) begin
      bad++; $display("FAIL reload_r1 got=%h exp=101112131415161718191a1b1c1d1e1f", bus.round_key_o);
    end
    bus.round_num_i = 4'd14;
    #1;
    total++;
    if (bus.round_key_o !== exp14) begin
      bad++; $display("FAIL reload_r14 got=%h exp=%h", bus.round_key_o, exp14);
    end
  endtask

`ifdef AES256_KEYEXP_ZEROIZE_EN
  task automatic test_zeroize();
    @(negedge clk);
    bus.key_clear_i = 1'b1;
    bus.key_load_i  = 1'b1;
    bus.key_i       = KEY_A3;
    @(negedge clk);
    bus.key_clear_i = 1'b0;
    bus.key_load_i  = 1'b0;
    total++;
    if (bus.key_exp_done_o !== 1'b0) begin bad++; $display("FAIL clear_done got=%b exp=0", bus.key_exp_done_o); end
    total++;
    if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL clear_busy got=%b exp=0", bus.busy_o); end
    for (int r = 0; r < 15; r++) begin
      bus.round_num_i = 4'(r);
      #1;
      total++;
      if (bus.round_key_o !== 128'h0) begin bad++; $display("FAIL clear_r%0d got=%h exp=0", r, bus.round_key_o); end
    end
    repeat (3) @(negedge clk);
    total++;
    if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL clear_idle_busy got=%b exp=0", bus.busy_o); end
  endtask
`endif

  initial begin
    total           = 0;
    bad             = 0;
    bus.key_load_i  = 1'b0;
    bus.key_i       = 256'h0;
    bus.round_num_i = 4'd0;
`ifdef AES256_KEYEXP_ZEROIZE_EN
    bus.key_clear_i = 1'b0;
`endif
    test_reset();
    test_fips_a3();
    test_sweep();
    test_load_held();
    test_reset_mid();
    test_back_to_back();
`ifdef AES256_KEYEXP_ZEROIZE_EN
    test_zeroize();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
